// File: rtl/obi_mgr_pkg.sv
// obi_mgr_pkg: shared state encoding, default widths and the command legality check for obi_mgr_be
package obi_mgr_pkg;
  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ADDR   = 2'b01,
    WAIT_R = 2'b10,
    RESP   = 2'b11
  } state_e;
  function automatic logic cmd_legal(input logic be_any, input logic [1:0] addr_lo);
    return be_any && addr_lo == 2'b00;
  endfunction
endpackage

// File: rtl/obi_mgr_wdog.sv
// obi_mgr_wdog: counts enabled cycles and flags the LIMIT-th one; clear restarts it
module obi_mgr_wdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);
  localparam int unsigned W = $clog2(LIMIT + 1);
  logic [W-1:0] r_cnt;
  assign o_expired = i_en && r_cnt == W'(LIMIT - 1);
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_en && !o_expired) r_cnt <= r_cnt + W'(1);
endmodule

// File: rtl/obi_mgr_be.sv
// obi_mgr_be: single-outstanding OBI manager with byte enables and alignment checking
// Optional WAIT_R watchdog with response draining is enabled by defining OBI_MGR_TIMEOUT_EN.
module obi_mgr_be import obi_mgr_pkg::*; #(
  parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic                    cmd_we_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    obi_req_o,
  input  logic                    obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]   obi_addr_o,
  output logic                    obi_we_o,
  output logic [DATA_WIDTH/8-1:0] obi_be_o,
  output logic [DATA_WIDTH-1:0]   obi_wdata_o,
  input  logic                    obi_rvalid_i,
  output logic                    obi_rready_o,
  input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
  input  logic                    obi_err_i,
  output logic                    busy_o
);
  localparam int unsigned BW = DATA_WIDTH / 8;
  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [BW-1:0]         r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  w_req;
  logic                  w_resp;
  logic                  w_expired;
  logic                  w_drain;
  assign w_req        = r_state == ADDR;
  assign w_resp       = r_state == RESP;
  assign busy_o       = r_state != IDLE;
  assign cmd_ready_o  = r_state == IDLE && !w_drain;
  assign obi_req_o    = w_req;
  assign obi_addr_o   = w_req ? r_addr : '0;
  assign obi_we_o     = w_req ? r_we : 1'b0;
  assign obi_be_o     = w_req ? r_be : '0;
  assign obi_wdata_o  = w_req ? r_wdata : '0;
  assign obi_rready_o = r_state == WAIT_R || w_drain;
  assign rsp_valid_o  = w_resp;
  assign rsp_rdata_o  = w_resp ? r_rdata : '0;
  assign rsp_err_o    = w_resp ? r_err : 1'b0;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (cmd_valid_i && cmd_ready_o) begin
          r_addr  <= cmd_addr_i;
          r_we    <= cmd_we_i;
          r_be    <= cmd_be_i;
          r_wdata <= cmd_wdata_i;
          r_rdata <= '0;
          r_err   <= !cmd_legal(|cmd_be_i, cmd_addr_i[1:0]);
          r_state <= cmd_legal(|cmd_be_i, cmd_addr_i[1:0]) ? ADDR : RESP;
        end
        ADDR: if (obi_gnt_i) r_state <= WAIT_R;
        WAIT_R: if (obi_rvalid_i) begin
          r_rdata <= r_we ? '0 : obi_rdata_i;
          r_err   <= obi_err_i;
          r_state <= RESP;
        end else if (w_expired) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
          r_state <= RESP;
        end
        default: if (rsp_ready_i) r_state <= IDLE;
      endcase
    end
`ifdef OBI_MGR_TIMEOUT_EN
  logic r_drain;
  obi_mgr_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .i_clear   (r_state != WAIT_R),
    .i_en      (r_state == WAIT_R),
    .o_expired (w_expired)
  );
  // a timed-out read still owes us one rvalid; swallow it before the next command
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) r_drain <= 1'b0;
    else if (r_state == WAIT_R && !obi_rvalid_i && w_expired) r_drain <= 1'b1;
    else if (r_drain && obi_rvalid_i) r_drain <= 1'b0;
  assign w_drain = r_drain;
`else
  assign w_expired = 1'b0;
  assign w_drain   = 1'b0;
`endif
endmodule

// File: tb/tb_obi_mgr_be.sv
// tb_obi_mgr_be: directed and randomized transactions checked against a rule-based expectation model
module tb_obi_mgr_be;
  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_addr_i = '0;
  logic        cmd_we_i = 1'b0;
  logic [3:0]  cmd_be_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        obi_req_o;
  logic        obi_gnt_i = 1'b0;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid_i = 1'b0;
  logic        obi_rready_o;
  logic [31:0] obi_rdata_i = '0;
  logic        obi_err_i = 1'b0;
  logic        busy_o;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  obi_mgr_be dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_we_i(cmd_we_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
    .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_rvalid_i(obi_rvalid_i), .obi_rready_o(obi_rready_o), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
    .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle();
    check("idle_cmd_ready", cmd_ready_o, 1);
    check("idle_busy", busy_o, 0);
    check("idle_req", obi_req_o, 0);
    check("idle_rsp_valid", rsp_valid_o, 0);
    check("idle_rready", obi_rready_o, 0);
  endtask

  // gd: cycles before gnt, rd: WAIT_R cycles before rvalid, bp: cycles rsp_ready held low
  task automatic do_txn(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd,
                        input int gd, input int rd, input logic [31:0] rdat, input logic e, input int bp);
    logic        legal = be != 4'h0 && a[1:0] == 2'b00;
    logic [31:0] exp_rdata = (!legal || we) ? 32'h0 : rdat;
    logic        exp_err = !legal || e;
    @(negedge clk);
    check("accept_ready", cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_we_i = we; cmd_be_i = be; cmd_wdata_i = wd;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0; cmd_addr_i = $urandom; cmd_be_i = 4'($urandom); cmd_wdata_i = $urandom;
    if (legal) begin
      for (int i = 0; i <= gd; i++) begin
        @(negedge clk);
        check("a_req", obi_req_o, 1);
        check("a_addr", obi_addr_o, a);
        check("a_we", obi_we_o, we);
        check("a_be", obi_be_o, be);
        check("a_wdata", obi_wdata_o, wd);
        check("a_cmd_ready", cmd_ready_o, 0);
        check("a_rready", obi_rready_o, 0);
        obi_gnt_i = i == gd;
        obi_rvalid_i = i != gd && $urandom_range(0, 1) == 1;
        obi_rdata_i = $urandom; obi_err_i = 1'b1;
      end
      @(posedge clk); #1;
      obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0;
      for (int j = 0; j <= rd; j++) begin
        @(negedge clk);
        check("r_req", obi_req_o, 0);
        check("r_addr_zero", obi_addr_o, 0);
        check("r_rready", obi_rready_o, 1);
        check("r_rsp_valid", rsp_valid_o, 0);
        check("r_busy", busy_o, 1);
        obi_rvalid_i = j == rd;
        obi_rdata_i = rdat; obi_err_i = e;
      end
      @(posedge clk); #1;
      obi_rvalid_i = 1'b0; obi_rdata_i = $urandom; obi_err_i = 1'b0;
    end
    for (int k = 0; k <= bp; k++) begin
      @(negedge clk);
      check("rsp_valid", rsp_valid_o, 1);
      check("rsp_rdata", rsp_rdata_o, exp_rdata);
      check("rsp_err", rsp_err_o, exp_err);
      check("rsp_cmd_ready", cmd_ready_o, 0);
      check("rsp_req", obi_req_o, 0);
      rsp_ready_i = k == bp;
    end
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_ni = 1'b1;
    @(negedge clk);
    check_idle();
    check("reset_rsp_err", rsp_err_o, 0);
    check("reset_rsp_rdata", rsp_rdata_o, 0);
    check("reset_addr", obi_addr_o, 0);
    do_txn(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 2, 0, 32'h12345678, 1'b0, 0);
    do_txn(32'h10, 1'b0, 4'hF, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 0);
    do_txn(32'h10, 1'b1, 4'h0, 32'hCAFEF00D, 0, 0, 32'h0, 1'b0, 0);
    do_txn(32'h13, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0, 1'b0, 0);
    do_txn(32'h24, 1'b0, 4'h3, 32'h0, 1, 2, 32'hA5A5_0F0F, 1'b0, 5);
    do_txn(32'h28, 1'b0, 4'h1, 32'h0, 0, 1, 32'h0BAD_0BAD, 1'b1, 0);
    @(negedge clk);
    check_idle();
`ifdef OBI_MGR_TIMEOUT_EN
    cmd_valid_i = 1'b1; cmd_addr_i = 32'h40; cmd_we_i = 1'b0; cmd_be_i = 4'hF;
    @(posedge clk); #1 cmd_valid_i = 1'b0;
    @(negedge clk);
    check("to_req", obi_req_o, 1);
    obi_gnt_i = 1'b1;
    @(posedge clk); #1 obi_gnt_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("to_wait_rready", obi_rready_o, 1);
      check("to_wait_rsp_valid", rsp_valid_o, 0);
    end
    @(negedge clk);
    check("to_rsp_valid", rsp_valid_o, 1);
    check("to_rsp_err", rsp_err_o, 1);
    check("to_rsp_rdata", rsp_rdata_o, 0);
    rsp_ready_i = 1'b1;
    @(posedge clk); #1 rsp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("drain_cmd_ready", cmd_ready_o, 0);
      check("drain_rready", obi_rready_o, 1);
      check("drain_rsp_valid", rsp_valid_o, 0);
    end
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'h5555AAAA;
    @(posedge clk); #1 obi_rvalid_i = 1'b0;
    @(negedge clk);
    check_idle();
    do_txn(32'h44, 1'b0, 4'hF, 32'h0, 0, 0, 32'h13579BDF, 1'b0, 0);
`endif
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_addr_i = 32'h20; cmd_we_i = 1'b0; cmd_be_i = 4'hF;
    @(posedge clk); #1 cmd_valid_i = 1'b0;
    @(negedge clk);
    obi_gnt_i = 1'b1;
    @(posedge clk); #1 obi_gnt_i = 1'b0;
    @(negedge clk);
    check("pre_reset_rready", obi_rready_o, 1);
    #1 reset_ni = 1'b0;
    #1;
    check("rst_req", obi_req_o, 0);
    check("rst_rready", obi_rready_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rsp_err", rsp_err_o, 0);
    @(negedge clk);
    reset_ni = 1'b1;
    @(negedge clk);
    check_idle();
    do_txn(32'h20, 1'b0, 4'hF, 32'h0, 0, 0, 32'hFEEDFACE, 1'b0, 0);
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a = {$urandom} & 32'hFFFF_FFFC;
      logic [3:0]  be = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) be = 4'h0;
      do_txn(a, 1'($urandom), be, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 3));
    end
    @(negedge clk);
    check_idle();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/obi_mgr_be.md
OBI_MGR_BE -- requirements
Module: obi_mgr_be

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: OBI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: OBI data width; byte-enable width is DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16: watchdog limit in cycles, only used when OBI_MGR_TIMEOUT_EN is defined.
REQ-004 SHALL have ports clk_i in 1 (clock); reset_ni in 1 (reset, asynchronous, active-low).
REQ-005 SHALL have command ports: cmd_valid_i in 1; cmd_ready_o out 1; cmd_addr_i in ADDR_WIDTH; cmd_we_i in 1; cmd_be_i in DATA_WIDTH/8; cmd_wdata_i in DATA_WIDTH.
REQ-006 SHALL have response ports: rsp_valid_o out 1; rsp_ready_i in 1; rsp_rdata_o out DATA_WIDTH; rsp_err_o out 1.
REQ-007 SHALL have OBI A-channel ports: obi_req_o out 1; obi_gnt_i in 1; obi_addr_o out ADDR_WIDTH; obi_we_o out 1; obi_be_o out DATA_WIDTH/8; obi_wdata_o out DATA_WIDTH.
REQ-008 SHALL have OBI R-channel ports: obi_rvalid_i in 1; obi_rready_o out 1; obi_rdata_i in DATA_WIDTH; obi_err_i in 1; plus busy_o out 1 (high when state != IDLE).

Function
REQ-009 SHALL implement FSM states IDLE, ADDR, WAIT_R, RESP; one transaction outstanding at most.
REQ-010 SHALL drive cmd_ready_o = (state==IDLE) and no drain pending; a command is accepted on the cycle cmd_valid_i && cmd_ready_o.
REQ-011 SHALL register addr/we/be/wdata on acceptance; IDLE->ADDR on the next edge (accept-to-req latency 1 cycle).
REQ-012 SHALL on acceptance with cmd_be_i==0 or cmd_addr_i[1:0]!=0 skip OBI: IDLE->RESP with rsp_err_o=1, rsp_rdata_o=0.
REQ-013 SHALL in ADDR drive obi_req_o=1 with registered A-channel signals held stable until obi_gnt_i; on gnt ADDR->WAIT_R.
REQ-014 SHALL drive obi_req_o=0 in every state other than ADDR; A-channel outputs are 0 when obi_req_o=0.
REQ-015 SHALL drive obi_rready_o=1 in WAIT_R (and while draining); on obi_rvalid_i capture obi_rdata_i (reads) or 0 (writes) and obi_err_i, WAIT_R->RESP.
REQ-016 SHALL tolerate obi_rvalid_i in the same cycle as obi_gnt_i being absent only in WAIT_R; rvalid in IDLE/ADDR/RESP without drain pending is ignored.
REQ-017 SHALL in RESP hold rsp_valid_o=1 with stable rsp_rdata_o/rsp_err_o until rsp_ready_i; RESP->IDLE on that edge.
REQ-018 SHALL allow back-to-back operation: new command accepted the cycle after RESP->IDLE (minimum 4 cycles per transaction with immediate gnt/rvalid/ready).

Reset
REQ-019 SHALL on reset_ni low force state IDLE, all registers 0, watchdog 0, drain flag 0, and all outputs 0 except cmd_ready_o=1 after release.
REQ-020 SHALL on reset mid-transaction abandon it: obi_req_o and rsp_valid_o drop asynchronously, no response is ever issued.

Configuration
REQ-021 SHALL with OBI_MGR_TIMEOUT_EN defined count WAIT_R cycles; on reaching TIMEOUT_CYCLES without rvalid go to RESP with rsp_err_o=1, rsp_rdata_o=0, and set drain flag.
REQ-022 SHALL while drain flag set hold obi_rready_o=1, cmd_ready_o=0; the next obi_rvalid_i clears it and is discarded.
REQ-023 SHALL without OBI_MGR_TIMEOUT_EN wait in WAIT_R indefinitely; no counter or drain flag logic is present.

Structure
REQ-024 SHALL place the state enum (2-bit, IDLE=2'b00), default width constants and the byte-enable/alignment check function in package obi_mgr_pkg.
REQ-025 SHALL put the watchdog counter in sub-module obi_mgr_wdog (inputs clear/enable, output expired), instantiated only under OBI_MGR_TIMEOUT_EN.

Verification
REQ-026 SHALL cover write: cmd addr=0x10, be=4'hF, wdata=0xDEADBEEF, gnt after 2 cycles -> obi_req_o stable 3 cycles, rsp_err_o=0, rsp_rdata_o=0.
REQ-027 SHALL cover read: cmd addr=0x10, we=0, obi_rdata_i=0xDEADBEEF, rvalid 1 cycle after gnt -> rsp_rdata_o=0xDEADBEEF, rsp_err_o=0.
REQ-028 SHALL cover illegal cmd: be=4'h0 or addr=0x13 -> no obi_req_o, rsp_valid_o next cycle with rsp_err_o=1.
REQ-029 SHALL cover backpressure: rsp_ready_i low 5 cycles -> rsp_valid_o and data held, cmd_ready_o=0 throughout.
REQ-030 SHALL cover timeout (macro on, TIMEOUT_CYCLES=16): no rvalid -> rsp_err_o=1 after 16 WAIT_R cycles; late rvalid discarded, then cmd_ready_o=1.
REQ-031 SHALL cover reset asserted in WAIT_R -> all outputs 0 immediately, clean read succeeds after release.
